// File: rtl/umi_arbiter.sv
// N-to-1 UMI arbiter: round-robin or fixed-priority grant of single-beat packets into a
// registered output stage, one packet per cycle with one cycle of latency.
module umi_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned UW = 256,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            umi_clk,
  input  logic            umi_reset,
  input  logic            arbmode,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*UW-1:0] umi_in_packet,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [UW-1:0]   umi_out_packet,
  output logic [SW-1:0]   umi_out_src,
  input  logic            umi_out_ready
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel;
  logic [SW-1:0] idx;
  logic          found;
  logic          load;
  logic          accept;
  logic [N-1:0]  gnt;
  logic [UW-1:0] sel_packet;

  // Scan order starts at ptr in round-robin mode and at channel 0 in fixed-priority mode.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = arbmode ? SW'(k) : SW'((32'(ptr_q) + k) % N);
      if (!found && umi_in_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    gnt = '0;
    if (found) gnt[sel] = 1'b1;
  end

  assign load         = ~umi_out_valid | umi_out_ready;
  assign umi_in_ready = gnt & {N{load}};
  assign accept       = found & load;

  always_comb begin
    sel_packet = umi_in_packet[32'(sel) * UW +: UW];
    // Explicit wrap so non-power-of-two N never reaches an unused pointer value.
    if (32'(sel) == N - 1) ptr_d = '0;
    else                   ptr_d = sel + 1'b1;
  end

  always_ff @(posedge umi_clk or posedge umi_reset) begin
    if (umi_reset) begin
      umi_out_valid  <= 1'b0;
      umi_out_packet <= '0;
      umi_out_src    <= '0;
      ptr_q          <= '0;
    end else if (accept) begin
      umi_out_valid  <= 1'b1;
      umi_out_packet <= sel_packet;
      umi_out_src    <= sel;
      ptr_q          <= ptr_d;
    end else begin
      umi_out_valid  <= umi_out_valid & ~umi_out_ready;
    end
  end

endmodule

// File: tb/tb_umi_arbiter.sv
// Scoreboard bench for umi_arbiter: directed arbitration scenarios plus a random soak,
// checked against a behavioural grant model and an in-order expected-output queue.
module tb_umi_arbiter;

  localparam int N  = 4;
  localparam int UW = 256;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            arbmode;
  logic [N-1:0]    vin;
  logic [N*UW-1:0] pin;
  logic [N-1:0]    rin;
  logic            ov;
  logic [UW-1:0]   op;
  logic [SW-1:0]   osrc;
  logic            ordy;

  always #5 clk = ~clk;

  umi_arbiter #(.N(N), .UW(UW)) dut (
    .umi_clk       (clk),
    .umi_reset     (rst),
    .arbmode       (arbmode),
    .umi_in_valid  (vin),
    .umi_in_packet (pin),
    .umi_in_ready  (rin),
    .umi_out_valid (ov),
    .umi_out_packet(op),
    .umi_out_src   (osrc),
    .umi_out_ready (ordy)
  );

  typedef struct {
    logic [UW-1:0] p;
    int            src;
  } item_t;

  item_t         sbq[$];
  logic [UW-1:0] pkt[N];
  int            waitc[N];
  int            checks = 0;
  int            errors = 0;
  int            seq = 0;
  int            m_ptr;
  bit            m_ov;
  bit            soak;
  int            acc;
  logic [N-1:0]  vcur;

  task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [UW-1:0] new_pkt(input int c);
    logic [UW-1:0] r;
    for (int w = 0; w < UW / 32; w++) r[w*32 +: 32] = $urandom;
    r[15:0]  = seq[15:0];
    r[19:16] = c[3:0];
    seq++;
    return r;
  endfunction

  // Reference grant: first valid channel in scan order, or -1 when none is valid.
  function automatic int pick(input logic [N-1:0] v, input bit mode, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = mode ? k : (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic step(input logic [N-1:0] v, input bit rdy, input bit mode, output int a);
    int           w;
    bit           ld;
    logic [N-1:0] er;
    vin     = v;
    ordy    = rdy;
    arbmode = mode;
    for (int c = 0; c < N; c++) pin[c*UW +: UW] = pkt[c];
    #1;
    w  = pick(v, mode, m_ptr);
    ld = !m_ov || rdy;
    er = '0;
    if (w >= 0 && ld) er[w] = 1'b1;
    chk("in_ready", rin, er);
    chk("out_valid", ov, m_ov);
    a = -1;
    if (w >= 0 && ld) begin
      a = w;
      sbq.push_back('{pkt[w], w});
      if (soak) chk("starve_wait", waitc[w] < N, 1);
      for (int c = 0; c < N; c++) begin
        if (c == w || !v[c]) waitc[c] = 0;
        else waitc[c]++;
      end
      pkt[w] = new_pkt(w);
      m_ptr  = (w + 1) % N;
      m_ov   = 1'b1;
    end else begin
      m_ov = m_ov && !rdy;
      for (int c = 0; c < N; c++) if (!v[c]) waitc[c] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: whenever the DUT presents a packet it must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ov) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got src %0d packet %0h expected none", osrc, op);
        end else begin
          chk("out_packet", op, sbq[0].p);
          chk("out_src", osrc, sbq[0].src);
          if (ordy) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    vin     = '1;
    ordy    = 1'b1;
    arbmode = 1'b0;
    soak    = 1'b0;
    m_ptr   = 0;
    m_ov    = 1'b0;
    for (int c = 0; c < N; c++) begin
      pkt[c]   = new_pkt(c);
      waitc[c] = 0;
      pin[c*UW +: UW] = pkt[c];
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", ov, 0);
    chk("reset_out_packet", op, 0);
    chk("reset_out_src", osrc, 0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin with every channel valid, then fixed priority on channels 1 and 3.
    repeat (8) step('1, 1'b1, 1'b0, acc);
    repeat (5) step(4'b1010, 1'b1, 1'b1, acc);
    repeat (2) step(4'b1000, 1'b1, 1'b1, acc);
    repeat (2) step(4'b0000, 1'b1, 1'b0, acc);

    // Backpressure holding channel 0, then drain-and-load of channel 2 on one edge.
    step(4'b0001, 1'b0, 1'b0, acc);
    repeat (5) step(4'b0100, 1'b0, 1'b0, acc);
    step(4'b0100, 1'b1, 1'b0, acc);

    // Pointer now 3 with only channels 0 and 1 requesting.
    step(4'b0011, 1'b1, 1'b0, acc);
    step(4'b0010, 1'b1, 1'b0, acc);
    repeat (2) step(4'b0000, 1'b1, 1'b0, acc);

    // Random soak: a valid channel holds its packet until accepted.
    soak = 1'b1;
    vcur = '0;
    repeat (3000) begin
      for (int c = 0; c < N; c++) if (!vcur[c]) vcur[c] = 1'($urandom_range(0, 1));
      step(vcur, $urandom_range(0, 3) != 0, 1'b0, acc);
      if (acc >= 0) vcur[acc] = 1'b0;
    end
    soak = 1'b0;
    repeat (4) step(4'b0000, 1'b1, 1'b0, acc);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
